// File: rtl/fb_port_arbiter_if.sv
// Framebuffer port bundle: display read client, graphics write client and the
// single memory port, plus the arbiter state for observation.
//
// Handshakes:
//   read  : client raises r_re with stable r_xpos/r_ypos/r_mode and holds it until
//           r_valid; r_dout is valid while r_valid; r_valid falls the cycle after
//           r_re is dropped. r_busy high means the framebuffer is still being cleared.
//   write : client raises w_req with stable fields and holds them until w_ack; w_ack
//           is a single-cycle completion pulse.
//   memory: arbiter raises mem_req with stable mem_* fields and holds it until the
//           memory returns a single-cycle mem_ack (mem_rdata valid with it).
interface fb_port_arbiter_if #(
  parameter int X_W = 8,
  parameter int Y_W = 8
);
  logic           r_re;
  logic [X_W-1:0] r_xpos;
  logic [Y_W-1:0] r_ypos;
  logic           r_mode;
  logic [7:0]     r_dout;
  logic           r_valid;
  logic           r_busy;

  logic           w_req;
  logic [X_W-1:0] w_xpos;
  logic [Y_W-1:0] w_ypos;
  logic           w_mode;
  logic [7:0]     w_data;
  logic           w_ack;

  logic           mem_req;
  logic           mem_we;
  logic [X_W-1:0] mem_xpos;
  logic [Y_W-1:0] mem_ypos;
  logic           mem_mode;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_rdata;
  logic           mem_ack;

  logic [2:0]     fsm_state;

  // Arbiter side.
  modport slave (
    input  r_re, r_xpos, r_ypos, r_mode,
    output r_dout, r_valid, r_busy,
    input  w_req, w_xpos, w_ypos, w_mode, w_data,
    output w_ack,
    output mem_req, mem_we, mem_xpos, mem_ypos, mem_mode, mem_wdata,
    input  mem_rdata, mem_ack,
    output fsm_state
  );

  // Clients and memory side.
  modport master (
    output r_re, r_xpos, r_ypos, r_mode,
    input  r_dout, r_valid, r_busy,
    output w_req, w_xpos, w_ypos, w_mode, w_data,
    input  w_ack,
    input  mem_req, mem_we, mem_xpos, mem_ypos, mem_mode, mem_wdata,
    output mem_rdata, mem_ack,
    input  fsm_state
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single framebuffer memory port between the display
// read client and the graphics write client. One memory op is in flight at a time
// and runs to completion before the next grant.
//
// Optional feature macro: CLEAR_ON_RESET_EN. When defined, the arbiter sweeps the
// whole framebuffer writing 0x00 after every reset (r_busy high meanwhile) before
// serving clients. When undefined, the arbiter is idle right after reset and
// r_busy is tied low.
//
// fsm_state encoding: 0 CLEAR, 1 IDLE, 2 RD, 3 RD_HOLD, 4 WR, 5 WR_DONE.
module fb_port_arbiter #(
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int COLS       = 128,
  parameter int PAGES      = 8,
  parameter int R_PRIORITY = 1
) (
  input logic              clk,
  input logic              reset_n,
  fb_port_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_HOLD = 3'd3,
    ST_WR      = 3'd4,
    ST_WR_DONE = 3'd5
  } state_t;

  // The clear sweep must be addressable with the configured widths.
  if (COLS < 1 || COLS > (1 << X_W) || PAGES < 1 || PAGES * 8 > (1 << Y_W)) begin : g_bad_cfg
    $error("fb_port_arbiter: clear sweep does not fit the address widths");
  end

`ifdef CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = ST_CLEAR;
  logic [X_W-1:0] clr_x;
  logic [Y_W-1:0] clr_page;
`else
  localparam state_t RESET_STATE = ST_IDLE;
  // No clear sweep: the framebuffer is always ready.
  assign bus.r_busy = 1'b0;
`endif

  state_t state;
  logic   last_grant_rd;  // 1: read client got the most recent grant
  logic   grant_rd;

  assign bus.fsm_state = state;

  // Read wins when alone, when reads have fixed priority, or when write went last.
  always_comb begin
    grant_rd = bus.r_re && (!bus.w_req || (R_PRIORITY != 0) || !last_grant_rd);
  end

  // Arbitration, memory op sequencing and every client/memory output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_STATE;
      last_grant_rd <= 1'b0;
      bus.r_dout    <= 8'h00;
      bus.r_valid   <= 1'b0;
      bus.w_ack     <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_xpos  <= '0;
      bus.mem_ypos  <= '0;
      bus.mem_mode  <= 1'b0;
      bus.mem_wdata <= 8'h00;
`ifdef CLEAR_ON_RESET_EN
      bus.r_busy    <= 1'b1;
      clr_x         <= '0;
      clr_page      <= '0;
`endif
    end else begin
      case (state)
`ifdef CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          if (!bus.mem_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_mode  <= 1'b1;
            bus.mem_wdata <= 8'h00;
            bus.mem_xpos  <= clr_x;
            bus.mem_ypos  <= clr_page << 3;
          end else if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (clr_x == X_W'(COLS - 1)) begin
              clr_x <= '0;
              if (clr_page == Y_W'(PAGES - 1)) begin
                clr_page   <= '0;
                bus.r_busy <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                clr_page <= clr_page + Y_W'(1);
              end
            end else begin
              clr_x <= clr_x + X_W'(1);
            end
          end
        end
`endif
        ST_IDLE: begin
          if (grant_rd) begin
            // Reads carry no data; wdata is parked at zero.
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_xpos  <= bus.r_xpos;
            bus.mem_ypos  <= bus.r_ypos;
            bus.mem_mode  <= bus.r_mode;
            bus.mem_wdata <= 8'h00;
            last_grant_rd <= 1'b1;
            state         <= ST_RD;
          end else if (bus.w_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b1;
            bus.mem_xpos  <= bus.w_xpos;
            bus.mem_ypos  <= bus.w_ypos;
            bus.mem_mode  <= bus.w_mode;
            bus.mem_wdata <= bus.w_data;
            last_grant_rd <= 1'b0;
            state         <= ST_WR;
          end
        end
        ST_RD: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.r_dout  <= bus.mem_rdata;
            bus.r_valid <= 1'b1;
            state       <= ST_RD_HOLD;
          end
        end
        ST_RD_HOLD: begin
          // Data stays presented until the client lets go of r_re.
          if (!bus.r_re) begin
            bus.r_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.w_ack   <= 1'b1;
            state       <= ST_WR_DONE;
          end
        end
        ST_WR_DONE: begin
          // One cycle of w_ack lets the client drop w_req before IDLE samples it.
          bus.w_ack <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
